pc_sequencer: RTL and testbench

Parametrised program-counter unit for the single-issue core. Owns the architectural PC register and resolves the next PC each cycle: sequential, conditional/unconditional PC-relative branch (B), or register-indirect branch (BR). It also handles stall and halt. Sits in the fetch stage, feeding the instruction-memory address. Decode/execute supplies condition code, immediate, flags and register target.

---
 rtl/pc_pkg.sv | 41 ++++
 rtl/pc_ras.sv | 72 +++++++
 rtl/pc_sequencer.sv | 160 ++++++++++++++++
 tb/tb_pc_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types and helpers for the program-counter sequencer and its return-address stack.
package pc_pkg;

  typedef enum logic [2:0] {
    CC_NE  = 3'b000,
    CC_EQ  = 3'b001,
    CC_GT  = 3'b010,
    CC_LT  = 3'b011,
    CC_GE  = 3'b100,
    CC_LE  = 3'b101,
    CC_OVF = 3'b110,
    CC_UNC = 3'b111
  } ccode_e;

  localparam int FLG_V = 2;
  localparam int FLG_N = 1;
  localparam int FLG_Z = 0;

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } run_state_e;

  // Branch condition evaluation against the V/N/Z flag word.
  function automatic logic cond_met(input ccode_e cc, input logic [2:0] fl);
    logic met;
    case (cc)
      CC_NE:   met = ~fl[FLG_Z];
      CC_EQ:   met = fl[FLG_Z];
      CC_GT:   met = ~fl[FLG_Z] & ~fl[FLG_N];
      CC_LT:   met = fl[FLG_N];
      CC_GE:   met = fl[FLG_Z] | (~fl[FLG_Z] & ~fl[FLG_N]);
      CC_LE:   met = fl[FLG_Z] | fl[FLG_N];
      CC_OVF:  met = fl[FLG_V];
      CC_UNC:  met = 1'b1;
      default: met = 1'b0;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: a push when full overwrites the oldest entry,
// a pop when empty leaves the stack untouched; both report err combinationally.
module pc_ras
  import pc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         full,
  output logic         empty,
  output logic         err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] top_ptr_s;

  // ptr_q is the next write slot; the newest entry sits just below it.
  assign top_ptr_s = ptr_q - PTR_W'(1);
  assign top_data  = mem_q[top_ptr_s];
  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign empty     = (cnt_q == {CNT_W{1'b0}});
  assign err       = (push & full) | (pop & ~push & empty);

  // Pointer and occupancy update; push takes precedence over pop.
  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (push) begin
      ptr_d = ptr_q + PTR_W'(1);
      if (!full) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else if (pop && !empty) begin
      ptr_d = top_ptr_s;
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= {PTR_W{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage, written on every push.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      mem_q[ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential, PC-relative (B) and register-indirect (BR)
// next-PC selection with stall and sticky halt. Define RAS_EN to add the return-address stack.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int              PC_W      = 16,
  parameter int              IMM_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC  = {PC_W{1'b0}},
  parameter int              RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             br_imm,
  input  logic             br_reg,
  input  logic             halt,
  input  logic [2:0]       ccode,
  input  logic [2:0]       flags,
  input  logic [IMM_W-1:0] imm,
  input  logic [PC_W-1:0]  reg_target,
  input  logic             call,
  input  logic             ret,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pc_plus2,
  output logic             taken,
  output logic             halted,
  output logic             ras_err
);

  run_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            taken_q, taken_d;
  logic            cond_s;
  logic            branch_s;
  logic [PC_W-2:0] imm_ext_s;
  logic [PC_W-1:0] b_target_s;
  logic [PC_W-1:0] r_target_s;

  assign pc_plus2   = pc_q + {{(PC_W-2){1'b0}}, 2'b10};
  // Word offset becomes a byte offset by appending a zero; the sign bit is replicated above it.
  assign imm_ext_s  = {{(PC_W-1-IMM_W){imm[IMM_W-1]}}, imm};
  assign b_target_s = pc_plus2 + {imm_ext_s, 1'b0};
  assign r_target_s = {reg_target[PC_W-1:1], 1'b0};

  // BR honours the condition code as well, so an unconditional BR uses CC_UNC.
  assign cond_s   = cond_met(ccode_e'(ccode), flags);
  assign branch_s = (br_reg | br_imm) & cond_s;

`ifdef RAS_EN
  logic            push_s;
  logic            pop_s;
  logic            ras_full_s;
  logic            ras_empty_s;
  logic            ras_err_s;
  logic [PC_W-1:0] ras_top_s;
  logic            ras_err_q;
  logic            unused_s;

  pc_ras #(
    .DEPTH (RAS_DEPTH),
    .W     (PC_W)
  ) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_plus2),
    .top_data  (ras_top_s),
    .full      (ras_full_s),
    .empty     (ras_empty_s),
    .err       (ras_err_s)
  );

  assign unused_s = reg_target[0] ^ ras_full_s;
`else
  logic unused_s;

  assign unused_s = reg_target[0] ^ call ^ ret;
`endif

  // Next-state and next-PC: stall > halted > halt > br_reg > br_imm > sequential.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    taken_d = 1'b0;
`ifdef RAS_EN
    push_s  = 1'b0;
    pop_s   = 1'b0;
`endif
    if (stall) begin
      pc_d = pc_q;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (halt) begin
            state_d = ST_HALTED;
          end else if (branch_s) begin
            taken_d = 1'b1;
            pc_d    = br_reg ? r_target_s : b_target_s;
`ifdef RAS_EN
            if (call) begin
              push_s = 1'b1;
            end else if (br_reg && ret) begin
              pop_s = 1'b1;
              if (!ras_empty_s) begin
                pc_d = ras_top_s;
              end else begin
                pc_d = r_target_s;
              end
            end else begin
              push_s = 1'b0;
            end
`endif
          end else begin
            pc_d = pc_plus2;
          end
        end
        ST_HALTED: begin
          state_d = ST_HALTED;
        end
        default: begin
          state_d = ST_HALTED;
        end
      endcase
    end
  end

  // Architectural state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      taken_q <= taken_d;
    end
  end

`ifdef RAS_EN
  // Stack error pulse; push/pop are already suppressed on stalled or halted cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ras_err_q <= 1'b0;
    end else begin
      ras_err_q <= ras_err_s;
    end
  end

  assign ras_err = ras_err_q;
`else
  assign ras_err = 1'b0;
`endif

  assign pc     = pc_q;
  assign taken  = taken_q;
  assign halted = (state_q == ST_HALTED);

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus a randomized run
// against a behavioural model of the next-PC rules.
module tb_pc_sequencer;

  localparam int          DEPTH  = 4;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        rst_n, stall, br_imm, br_reg, halt, call, ret;
  logic [2:0]  ccode, flags;
  logic [8:0]  imm;
  logic [15:0] reg_target;
  logic [15:0] pc, pc_plus2;
  logic        taken, halted, ras_err;

  int total = 0;
  int bad   = 0;

  logic [15:0] m_pc;
  bit          m_taken, m_halted, m_err;
  logic [15:0] m_stack[$];

  always #5 clk = ~clk;

  pc_sequencer #(
    .PC_W(16), .IMM_W(9), .RESET_PC(RST_PC), .RAS_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .br_imm(br_imm), .br_reg(br_reg),
    .halt(halt), .ccode(ccode), .flags(flags), .imm(imm), .reg_target(reg_target),
    .call(call), .ret(ret), .pc(pc), .pc_plus2(pc_plus2), .taken(taken),
    .halted(halted), .ras_err(ras_err)
  );

  function automatic bit m_cond(input logic [2:0] cc, input logic [2:0] f);
    bit v, n, z;
    v = f[2]; n = f[1]; z = f[0];
    case (cc)
      3'd0:    return !z;
      3'd1:    return z;
      3'd2:    return !z && !n;
      3'd3:    return n;
      3'd4:    return z || (!z && !n);
      3'd5:    return z || n;
      3'd6:    return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_step();
    logic [15:0] tgt;
    int off;
    m_taken = 1'b0;
    m_err   = 1'b0;
    if (!rst_n) begin
      m_pc = RST_PC; m_halted = 1'b0; m_stack.delete();
    end else if (stall || m_halted) begin
      m_taken = 1'b0;
    end else if (halt) begin
      m_halted = 1'b1;
    end else if ((br_reg || br_imm) && m_cond(ccode, flags)) begin
      if (br_reg) tgt = reg_target & 16'hFFFE;
      else begin
        off = $signed(imm);
        tgt = 16'(int'(m_pc) + 2 + 2 * off);
      end
`ifdef RAS_EN
      if (call) begin
        if (m_stack.size() == DEPTH) begin
          m_stack.delete(0);
          m_err = 1'b1;
        end
        m_stack.push_back(m_pc + 16'd2);
      end else if (ret && br_reg) begin
        if (m_stack.size() == 0) m_err = 1'b1;
        else tgt = m_stack.pop_back();
      end
`endif
      m_pc = tgt; m_taken = 1'b1;
    end else begin
      m_pc = m_pc + 16'd2;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst_n = 1'b1; stall = 1'b0; br_imm = 1'b0; br_reg = 1'b0; halt = 1'b0;
    call = 1'b0; ret = 1'b0; ccode = 3'd0; flags = 3'd0; imm = 9'd0; reg_target = 16'd0;
  endtask

  task automatic br_to(input logic [15:0] addr);
    idle();
    br_reg = 1'b1; ccode = 3'b111; reg_target = addr;
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1'b0; stall = 1'b1;
    step(); step();
    total++;
    if ({pc, taken, halted, ras_err} !== {16'h0000, 3'b000}) begin
      bad++;
      $display("FAIL reset: pc=%h taken=%b halted=%b ras_err=%b, want pc=0000 all flags 0", pc, taken, halted, ras_err);
    end
    idle();
    for (int i = 1; i <= 2; i++) begin
      step();
      total++;
      if ({pc, taken} !== {16'(2 * i), 1'b0}) begin
        bad++;
        $display("FAIL reset_seq%0d: pc=%h taken=%b, want pc=%h taken=0", i, pc, taken, 16'(2 * i));
      end
    end
  endtask

  task automatic test_cond_b();
    br_to(16'h0010);
    br_imm = 1'b1; ccode = 3'b001; flags = 3'b001; imm = 9'd3;
    step();
    total++;
    if ({pc, taken} !== {16'h0018, 1'b1}) begin
      bad++;
      $display("FAIL b_taken: pc=%h taken=%b, want pc=0018 taken=1", pc, taken);
    end
    br_to(16'h0010);
    br_imm = 1'b1; ccode = 3'b001; flags = 3'b000; imm = 9'd3;
    step();
    total++;
    if ({pc, taken} !== {16'h0012, 1'b0}) begin
      bad++;
      $display("FAIL b_not_taken: pc=%h taken=%b, want pc=0012 taken=0", pc, taken);
    end
  endtask

  task automatic test_wrap();
    br_to(16'h0004);
    br_imm = 1'b1; ccode = 3'b111; imm = 9'h1FC;
    step();
    total++;
    if ({pc, taken, pc_plus2} !== {16'hFFFE, 1'b1, 16'h0000}) begin
      bad++;
      $display("FAIL neg_off: pc=%h taken=%b pc_plus2=%h, want pc=fffe taken=1 pc_plus2=0000", pc, taken, pc_plus2);
    end
    idle();
    step();
    total++;
    if ({pc, taken} !== {16'h0000, 1'b0}) begin
      bad++;
      $display("FAIL seq_wrap: pc=%h taken=%b, want pc=0000 taken=0", pc, taken);
    end
  endtask

  task automatic test_br_stall();
    idle();
    br_reg = 1'b1; br_imm = 1'b1; ccode = 3'b111; imm = 9'd5; reg_target = 16'h1235;
    step();
    total++;
    if ({pc, taken} !== {16'h1234, 1'b1}) begin
      bad++;
      $display("FAIL br_conflict: pc=%h taken=%b, want pc=1234 taken=1", pc, taken);
    end
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1; br_reg = 1'b1; ccode = 3'b111;
      reg_target = 16'($urandom); halt = 1'($urandom_range(0, 1));
      step();
      total++;
      if ({pc, taken, halted} !== {16'h1234, 2'b00}) begin
        bad++;
        $display("FAIL stall%0d: pc=%h taken=%b halted=%b, want pc=1234 taken=0 halted=0", i, pc, taken, halted);
      end
    end
    idle();
    step();
    total++;
    if (pc !== 16'h1236) begin
      bad++;
      $display("FAIL post_stall: pc=%h, want 1236", pc);
    end
  endtask

  task automatic test_halt();
    br_to(16'h0040);
    halt = 1'b1; br_reg = 1'b1; ccode = 3'b111; reg_target = 16'h0800;
    step();
    total++;
    if ({pc, taken, halted} !== {16'h0040, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL halt: pc=%h taken=%b halted=%b, want pc=0040 taken=0 halted=1", pc, taken, halted);
    end
    for (int i = 0; i < 3; i++) begin
      idle();
      br_reg = 1'($urandom_range(0, 1)); br_imm = 1'b1; ccode = 3'b111;
      imm = 9'($urandom); reg_target = 16'h0800;
      step();
      total++;
      if ({pc, taken, halted} !== {16'h0040, 1'b0, 1'b1}) begin
        bad++;
        $display("FAIL halted_hold%0d: pc=%h taken=%b halted=%b, want pc=0040 taken=0 halted=1", i, pc, taken, halted);
      end
    end
    idle();
    rst_n = 1'b0;
    step();
    total++;
    if ({pc, halted} !== {RST_PC, 1'b0}) begin
      bad++;
      $display("FAIL halt_reset: pc=%h halted=%b, want pc=%h halted=0", pc, halted, RST_PC);
    end
    idle();
  endtask

`ifdef RAS_EN
  task automatic test_ras();
    idle(); rst_n = 1'b0; step();
    br_to(16'h0100);
    for (int i = 0; i < 5; i++) begin
      idle(); br_imm = 1'b1; ccode = 3'b111; imm = 9'd0; call = 1'b1;
      step();
      total++;
      if ({pc, ras_err} !== {16'(16'h0100 + 2 * (i + 1)), (i == 4)}) begin
        bad++;
        $display("FAIL ras_call%0d: pc=%h ras_err=%b, want pc=%h ras_err=%b", i, pc, ras_err, 16'(16'h0100 + 2 * (i + 1)), (i == 4));
      end
    end
    for (int i = 0; i < 5; i++) begin
      idle(); br_reg = 1'b1; ccode = 3'b111; ret = 1'b1; reg_target = 16'h2001;
      step();
      total++;
      if ({pc, ras_err} !== {((i == 4) ? 16'h2000 : 16'(16'h010A - 2 * i)), (i == 4)}) begin
        bad++;
        $display("FAIL ras_ret%0d: pc=%h ras_err=%b, want pc=%h ras_err=%b", i, pc, ras_err, ((i == 4) ? 16'h2000 : 16'(16'h010A - 2 * i)), (i == 4));
      end
    end
    idle();
  endtask
`else
  task automatic test_ras_off();
    idle(); br_reg = 1'b1; ccode = 3'b111; call = 1'b1; ret = 1'b1; reg_target = 16'h0300;
    step();
    total++;
    if ({pc, ras_err} !== {16'h0300, 1'b0}) begin
      bad++;
      $display("FAIL ras_off_call: pc=%h ras_err=%b, want pc=0300 ras_err=0", pc, ras_err);
    end
    idle(); br_reg = 1'b1; ccode = 3'b111; ret = 1'b1; reg_target = 16'h0501;
    step();
    total++;
    if ({pc, ras_err} !== {16'h0500, 1'b0}) begin
      bad++;
      $display("FAIL ras_off_ret: pc=%h ras_err=%b, want pc=0500 ras_err=0", pc, ras_err);
    end
    idle();
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst_n      = ($urandom_range(0, 39) != 0);
      stall      = ($urandom_range(0, 4) == 0);
      halt       = ($urandom_range(0, 59) == 0);
      br_reg     = ($urandom_range(0, 3) == 0);
      br_imm     = 1'($urandom_range(0, 1));
      ccode      = br_reg ? 3'b111 : 3'($urandom_range(0, 7));
      flags      = 3'($urandom);
      imm        = 9'($urandom);
      reg_target = 16'($urandom);
      call       = ($urandom_range(0, 3) == 0);
      ret        = ($urandom_range(0, 2) == 0);
      step();
      total++;
      if ({pc, taken, halted, ras_err} !== {m_pc, m_taken, m_halted, m_err}) begin
        bad++;
        $display("FAIL rand%0d: pc=%h taken=%b halted=%b ras_err=%b, want pc=%h taken=%b halted=%b ras_err=%b",
                 i, pc, taken, halted, ras_err, m_pc, m_taken, m_halted, m_err);
      end
      total++;
      if (pc_plus2 !== m_pc + 16'd2) begin
        bad++;
        $display("FAIL rand_pc_plus2%0d: got %h, want %h", i, pc_plus2, m_pc + 16'd2);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    test_reset();
    test_cond_b();
    test_wrap();
    test_br_stall();
    test_halt();
`ifdef RAS_EN
    test_ras();
`else
    test_ras_off();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
